// File: rtl/vcm_focus_sweep.sv
// ---------------------------------------------------------------------------
// vcm_focus_sweep
// Contrast-autofocus sequencer feeding the VCM I2C writer. Steps the lens
// code across [POS_START, POS_END] in POS_STEP increments. Each code is
// presented on VCM_DATA with a TR strobe. After each step the block waits for
// mechanical settling, discards FRAMES_SKIP frames, then takes one sharpness
// score. At the end of the sweep it parks the lens on the best-scoring code.
//
// state        | meaning
// -------------+---------------------------------------------------------
// S_IDLE       | waiting for START; outputs hold the last sweep result
// S_LOAD       | place the current code on VCM_DATA
// S_TRIG       | raise TR for one cycle, arm the settle timer
// S_SETTLE     | lens settling; focus strobes ignored
// S_SKIP       | discard FRAMES_SKIP focus strobes (stale frames)
// S_MEAS       | take one score, update best on strictly greater
// S_NEXT       | advance code, or pick the park position when out of range
// S_PARK_LOAD  | place the best code on VCM_DATA
// S_PARK_TRIG  | raise TR for the park move, arm the settle timer
// S_PARK_SETTLE| wait for the park move, then pulse DONE
// ---------------------------------------------------------------------------
module vcm_focus_sweep #(
    parameter logic [9:0] POS_START   = 10'd0,
    parameter logic [9:0] POS_END     = 10'd1020,
    parameter logic [9:0] POS_STEP    = 10'd32,
    parameter int         SETTLE_CYC  = 4000,
    parameter int         FRAMES_SKIP = 1,
    parameter logic [3:0] SLEW        = 4'h0
) (
    input  logic        CLK_400K,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [17:0] FOCUS_VALUE,
    input  logic        FOCUS_VALID,
    output logic [15:0] VCM_DATA,
    output logic        TR,
    output logic        BUSY,
    output logic        DONE,
    output logic [9:0]  CUR_POS,
    output logic [9:0]  BEST_POS,
    output logic [17:0] BEST_VAL
);

    // Settle timer is a down-counter loaded with SETTLE_CYC-1; zero is terminal.
    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);

    // Skip counter counts discarded frames up to FRAMES_SKIP-1.
    localparam int SKW = (FRAMES_SKIP > 1) ? $clog2(FRAMES_SKIP) : 1;
    localparam logic [SKW-1:0] SKIP_LAST = SKW'(FRAMES_SKIP - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_TRIG,
        S_SETTLE,
        S_SKIP,
        S_MEAS,
        S_NEXT,
        S_PARK_LOAD,
        S_PARK_TRIG,
        S_PARK_SETTLE
    } state_t;

    state_t           state_q;
    logic [15:0]      vcm_data_q;
    logic             tr_q;
    logic             busy_q;
    logic             done_q;
    logic [9:0]       cur_pos_q;
    logic [9:0]       best_pos_q;
    logic [17:0]      best_val_q;
    logic             first_q;
    logic [SCW-1:0]   settle_cnt_q;
    logic [SKW-1:0]   skip_cnt_q;

    // The step sum is one bit wider so codes near the top cannot wrap to 0.
    logic [10:0]      next_pos_d;
    logic             next_in_range_d;

    function automatic logic [15:0] payload(input logic [9:0] pos);
        return {2'b00, pos, SLEW};
    endfunction

    // Candidate next lens code and its range test.
    always_comb begin
        next_pos_d      = {1'b0, cur_pos_q} + {1'b0, POS_STEP};
        next_in_range_d = (next_pos_d <= {1'b0, POS_END});
    end

    // Sweep sequencer with registered outputs; TR and DONE are single-cycle.
    always_ff @(posedge CLK_400K or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            vcm_data_q   <= 16'h0000;
            tr_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cur_pos_q    <= 10'd0;
            best_pos_q   <= 10'd0;
            best_val_q   <= 18'd0;
            first_q      <= 1'b0;
            settle_cnt_q <= '0;
            skip_cnt_q   <= '0;
        end else begin
            tr_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        busy_q     <= 1'b1;
                        cur_pos_q  <= POS_START;
                        best_pos_q <= POS_START;
                        best_val_q <= 18'd0;
                        first_q    <= 1'b1;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Payload lands one cycle ahead of TR so the writer sees stable data.
                    vcm_data_q <= payload(cur_pos_q);
                    state_q    <= S_TRIG;
                end
                S_TRIG: begin
                    tr_q         <= 1'b1;
                    settle_cnt_q <= SETTLE_LAST;
                    skip_cnt_q   <= '0;
                    state_q      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt_q == '0) begin
                        state_q <= S_SKIP;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 1'b1;
                    end
                end
                S_SKIP: begin
                    if (FRAMES_SKIP == 0) begin
                        state_q <= S_MEAS;
                    end else if (FOCUS_VALID) begin
                        if (skip_cnt_q == SKIP_LAST) begin
                            skip_cnt_q <= '0;
                            state_q    <= S_MEAS;
                        end else begin
                            skip_cnt_q <= skip_cnt_q + 1'b1;
                        end
                    end
                end
                S_MEAS: begin
                    if (FOCUS_VALID) begin
                        // Strictly greater keeps the lowest code on ties.
                        if (first_q || (FOCUS_VALUE > best_val_q)) begin
                            best_val_q <= FOCUS_VALUE;
                            best_pos_q <= cur_pos_q;
                        end
                        first_q <= 1'b0;
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (next_in_range_d) begin
                        cur_pos_q <= next_pos_d[9:0];
                        state_q   <= S_LOAD;
                    end else begin
                        cur_pos_q <= best_pos_q;
                        state_q   <= S_PARK_LOAD;
                    end
                end
                S_PARK_LOAD: begin
                    vcm_data_q <= payload(best_pos_q);
                    state_q    <= S_PARK_TRIG;
                end
                S_PARK_TRIG: begin
                    tr_q         <= 1'b1;
                    settle_cnt_q <= SETTLE_LAST;
                    state_q      <= S_PARK_SETTLE;
                end
                S_PARK_SETTLE: begin
                    if (settle_cnt_q == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign VCM_DATA = vcm_data_q;
    assign TR       = tr_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign CUR_POS  = cur_pos_q;
    assign BEST_POS = best_pos_q;
    assign BEST_VAL = best_val_q;

endmodule

// File: tb/tb_vcm_focus_sweep.sv
// ---------------------------------------------------------------------------
// tb_vcm_focus_sweep
// Two instances: a short main sweep (0..96 step 32, one skipped frame) and a
// range-edge sweep (0..1023 step 1000, no skipped frames). Expected codes and
// the best position come from a list-based model of the sweep rules.
// ---------------------------------------------------------------------------
module tb_vcm_focus_sweep;

    localparam int SET_M = 8, SKIP_M = 1, START_M = 0, END_M = 96,   STEP_M = 32;
    localparam int SET_E = 8, SKIP_E = 0, START_E = 0, END_E = 1023, STEP_E = 1000;
    localparam int JUNK  = 999;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_m, start_e;
    logic [17:0] fv_value;
    logic        fv_valid;

    logic [15:0] vcm_m, vcm_e;
    logic        tr_m, tr_e, busy_m, busy_e, done_m, done_e;
    logic [9:0]  cur_m, cur_e, bpos_m, bpos_e;
    logic [17:0] bval_m, bval_e;

    always #5 clk = ~clk;

    vcm_focus_sweep #(
        .POS_START(10'(START_M)), .POS_END(10'(END_M)), .POS_STEP(10'(STEP_M)),
        .SETTLE_CYC(SET_M), .FRAMES_SKIP(SKIP_M), .SLEW(4'h0)
    ) dut (
        .CLK_400K(clk), .RESET_N(rst_n), .START(start_m),
        .FOCUS_VALUE(fv_value), .FOCUS_VALID(fv_valid),
        .VCM_DATA(vcm_m), .TR(tr_m), .BUSY(busy_m), .DONE(done_m),
        .CUR_POS(cur_m), .BEST_POS(bpos_m), .BEST_VAL(bval_m)
    );

    vcm_focus_sweep #(
        .POS_START(10'(START_E)), .POS_END(10'(END_E)), .POS_STEP(10'(STEP_E)),
        .SETTLE_CYC(SET_E), .FRAMES_SKIP(SKIP_E), .SLEW(4'h0)
    ) dut_edge (
        .CLK_400K(clk), .RESET_N(rst_n), .START(start_e),
        .FOCUS_VALUE(fv_value), .FOCUS_VALID(fv_valid),
        .VCM_DATA(vcm_e), .TR(tr_e), .BUSY(busy_e), .DONE(done_e),
        .CUR_POS(cur_e), .BEST_POS(bpos_e), .BEST_VAL(bval_e)
    );

    int nchk = 0;
    int nerr = 0;

    // Observed-side bookkeeping of trigger and done pulses.
    int   tr_cnt_m = 0, tr_cnt_e = 0, done_cnt_m = 0, done_cnt_e = 0, tr_dbl = 0;
    logic tr_prev_m = 1'b0, tr_prev_e = 1'b0;
    always @(negedge clk) begin
        if (tr_m) tr_cnt_m <= tr_cnt_m + 1;
        if (tr_e) tr_cnt_e <= tr_cnt_e + 1;
        if (done_m) done_cnt_m <= done_cnt_m + 1;
        if (done_e) done_cnt_e <= done_cnt_e + 1;
        if ((tr_m && tr_prev_m) || (tr_e && tr_prev_e)) tr_dbl <= tr_dbl + 1;
        tr_prev_m <= tr_m;
        tr_prev_e <= tr_e;
    end

    // Instance selected by the current test step.
    int          sel = 0;
    logic [15:0] vcm_s;
    logic        tr_s, busy_s, done_s;
    logic [9:0]  cur_s, bpos_s;
    logic [17:0] bval_s;
    assign vcm_s  = (sel != 0) ? vcm_e  : vcm_m;
    assign tr_s   = (sel != 0) ? tr_e   : tr_m;
    assign busy_s = (sel != 0) ? busy_e : busy_m;
    assign done_s = (sel != 0) ? done_e : done_m;
    assign cur_s  = (sel != 0) ? cur_e  : cur_m;
    assign bpos_s = (sel != 0) ? bpos_e : bpos_m;
    assign bval_s = (sel != 0) ? bval_e : bval_m;

    // Reference model state: visited codes, scores, and the winner.
    int          pts[$];
    int unsigned scores[$];
    int          best_pos, best_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int payload(input int p);
        return p * 16;
    endfunction

    task automatic build_pts(input int s, input int e, input int st);
        int p;
        pts.delete();
        p = s;
        for (int g = 0; g < 1100; g++) begin
            pts.push_back(p);
            if (p + st > e) break;
            p = p + st;
        end
    endtask

    task automatic fill_random();
        scores.delete();
        foreach (pts[i]) scores.push_back($urandom_range(0, JUNK - 1));
    endtask

    task automatic model_best();
        int bi;
        bi = 0;
        foreach (scores[i]) if (scores[i] > scores[bi]) bi = i;
        best_pos = pts[bi];
        best_val = int'(scores[bi]);
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) start_m = v; else start_e = v;
    endtask

    task automatic wait_tr(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tr_s) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Called on the TR cycle: junk frame mid-settle, junk frames to be skipped,
    // then the real score. Optionally pokes START while busy.
    task automatic feed_point(input int unsigned score, input int settle, input int nskip, input bit poke);
        int kmax;
        kmax = settle + 2 + 2 * nskip;
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            fv_valid = 1'b0;
            if (poke && k == 5) set_start(1'b1);
            if (poke && k == 6) set_start(1'b0);
            if (k == 3 || (k >= settle + 2 && k < kmax && ((k - settle) % 2 == 0))) begin
                fv_valid = 1'b1;
                fv_value = 18'(JUNK);
            end
            if (k == kmax) begin
                fv_valid = 1'b1;
                fv_value = 18'(score);
            end
        end
        @(negedge clk);
        fv_valid = 1'b0;
    endtask

    task automatic run_sweep(input int settle, input int nskip, input bit poke);
        int t0, d0, lat;
        bit ok;
        model_best();
        #1;
        t0 = (sel != 0) ? tr_cnt_e : tr_cnt_m;
        d0 = (sel != 0) ? done_cnt_e : done_cnt_m;
        foreach (pts[i]) begin
            wait_tr(ok);
            chk("tr_seen", 32'(ok), 32'd1);
            if (!ok) return;
            chk("payload", 32'(vcm_s), 32'(payload(pts[i])));
            chk("cur_pos", 32'(cur_s), 32'(pts[i]));
            chk("busy_in_sweep", 32'(busy_s), 32'd1);
            feed_point(scores[i], settle, nskip, poke && (i == 1));
        end
        wait_tr(ok);
        chk("park_tr", 32'(ok), 32'd1);
        if (!ok) return;
        chk("park_payload", 32'(vcm_s), 32'(payload(best_pos)));
        lat = 0;
        for (int c = 1; c <= settle + 20; c++) begin
            @(negedge clk);
            if (done_s) begin
                lat = c;
                break;
            end
        end
        chk("done_latency", 32'(lat), 32'(settle));
        chk("best_pos", 32'(bpos_s), 32'(best_pos));
        chk("best_val", 32'(bval_s), 32'(best_val));
        chk("busy_at_done", 32'(busy_s), 32'd0);
        chk("cur_at_done", 32'(cur_s), 32'(best_pos));
        #1;
        chk("tr_count", 32'(((sel != 0) ? tr_cnt_e : tr_cnt_m) - t0), 32'(pts.size() + 1));
        chk("done_count", 32'(((sel != 0) ? done_cnt_e : done_cnt_m) - d0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int dsnap, tsnap;
        rst_n    = 1'b0;
        start_m  = 1'b0;
        start_e  = 1'b0;
        fv_valid = 1'b0;
        fv_value = 18'd0;
        repeat (3) @(negedge clk);

        // Reset values.
        chk("rst_vcm", 32'(vcm_m), 32'h0);
        chk("rst_tr", 32'(tr_m), 32'h0);
        chk("rst_busy", 32'(busy_m), 32'h0);
        chk("rst_done", 32'(done_m), 32'h0);
        chk("rst_cur", 32'(cur_m), 32'h0);
        chk("rst_bpos", 32'(bpos_m), 32'h0);
        chk("rst_bval", 32'(bval_m), 32'h0);
        chk("rst_edge_busy", 32'(busy_e), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ties plus discarded 999 frames, with START poked mid-sweep.
        sel = 0;
        build_pts(START_M, END_M, STEP_M);
        scores = '{10, 50, 50, 20};
        start_m = 1'b1;
        @(negedge clk);
        chk("busy_after_start", 32'(busy_m), 32'd1);
        start_m = 1'b0;
        run_sweep(SET_M, SKIP_M, 1'b1);
        repeat (5) @(negedge clk);
        chk("hold_vcm", 32'(vcm_m), 32'h0200);
        chk("hold_bpos", 32'(bpos_m), 32'd32);
        chk("hold_bval", 32'(bval_m), 32'd50);
        chk("hold_busy", 32'(busy_m), 32'd0);

        // All-zero scores park on the first code.
        scores = '{0, 0, 0, 0};
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        run_sweep(SET_M, SKIP_M, 1'b0);

        // Range edge: 0 and 1000 only, no wrap of the 2000 sum.
        sel = 1;
        build_pts(START_E, END_E, STEP_E);
        chk("edge_model_pts", 32'(pts.size()), 32'd2);
        fill_random();
        start_e = 1'b1;
        @(negedge clk);
        start_e = 1'b0;
        run_sweep(SET_E, SKIP_E, 1'b0);

        // Random sweeps on the main instance; the last holds START through DONE.
        sel = 0;
        build_pts(START_M, END_M, STEP_M);
        for (int r = 0; r < 3; r++) begin
            fill_random();
            start_m = 1'b1;
            @(negedge clk);
            if (r != 2) start_m = 1'b0;
            run_sweep(SET_M, SKIP_M, 1'b0);
        end
        @(negedge clk);
        chk("restart_busy", 32'(busy_m), 32'd1);
        chk("restart_bval", 32'(bval_m), 32'd0);
        chk("restart_cur", 32'(cur_m), 32'(START_M));
        chk("restart_done", 32'(done_m), 32'd0);
        start_m = 1'b0;

        // Reset during the third settle of the restarted sweep.
        for (int i = 0; i < 2; i++) begin
            wait_tr(ok);
            chk("pre_rst_tr", 32'(ok), 32'd1);
            feed_point(100 + i, SET_M, SKIP_M, 1'b0);
        end
        wait_tr(ok);
        chk("third_tr", 32'(ok), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tr", 32'(tr_m), 32'h0);
        chk("mid_rst_busy", 32'(busy_m), 32'h0);
        chk("mid_rst_vcm", 32'(vcm_m), 32'h0);
        chk("mid_rst_cur", 32'(cur_m), 32'h0);
        chk("mid_rst_bpos", 32'(bpos_m), 32'h0);
        chk("mid_rst_bval", 32'(bval_m), 32'h0);
        dsnap = done_cnt_m;
        tsnap = tr_cnt_m;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        chk("no_done_after_rst", 32'(done_cnt_m), 32'(dsnap));
        chk("no_tr_after_rst", 32'(tr_cnt_m), 32'(tsnap));
        chk("idle_after_rst", 32'(busy_m), 32'd0);

        // Full sweep again from POS_START.
        fill_random();
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        run_sweep(SET_M, SKIP_M, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        chk("tr_never_double", 32'(tr_dbl), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
